// File: rtl/matrix_scan_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : matrix_scan_sequencer
// Description : Row/column scan sequencer for resistive sensor matrices.
//               Drives mux selects, handshakes the ADC and emits tagged pixels.
// Revision    : 1.0 - initial release
// ============================================================================
module matrix_scan_sequencer #(
  parameter int ROWS        = 16,
  parameter int COLS        = 16,
  parameter int ROW_W       = 4,
  parameter int COL_W       = 4,
  parameter int DATA_W      = 12,
  parameter int SETTLE_CYC  = 10,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mode_cont,
  input  logic              start,
  input  logic              abort,
  output logic [ROW_W-1:0]  row_sel,
  output logic [COL_W-1:0]  col_sel,
  output logic              mux_en,
  output logic              adc_start,
  input  logic              adc_done,
  input  logic [DATA_W-1:0] adc_data,
  output logic              px_valid,
  output logic [DATA_W-1:0] px_data,
  output logic [ROW_W-1:0]  px_row,
  output logic [COL_W-1:0]  px_col,
  output logic              px_last,
  output logic              frame_start,
  output logic              frame_done,
  output logic              busy,
  output logic              timeout_err
);

  localparam int CNT_MAX = (SETTLE_CYC > TIMEOUT_CYC) ? SETTLE_CYC : TIMEOUT_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] c_settle_last  = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] c_timeout_last = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [ROW_W-1:0] c_row_last     = ROW_W'(ROWS - 1);
  localparam logic [COL_W-1:0] c_col_last     = COL_W'(COLS - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SELECT  = 3'd1,
    S_SETTLE  = 3'd2,
    S_CONVERT = 3'd3,
    S_WAIT    = 3'd4,
    S_EMIT    = 3'd5
  } state_t;

  state_t           r_state;
  logic [ROW_W-1:0] r_row_ptr;
  logic [COL_W-1:0] r_col_ptr;
  logic [CNT_W-1:0] r_cnt;

  logic             w_col_wrap;
  logic             w_row_wrap;
  logic             w_last;
  logic             w_wait_exit;
  logic [ROW_W-1:0] w_row_next;
  logic [COL_W-1:0] w_col_next;

  // Wrap by comparing against the dimension, so non-power-of-2 sizes work.
  assign w_col_wrap  = (r_col_ptr == c_col_last);
  assign w_row_wrap  = (r_row_ptr == c_row_last);
  assign w_last      = w_col_wrap && w_row_wrap;
  assign w_col_next  = w_col_wrap ? '0 : r_col_ptr + COL_W'(1);
  assign w_row_next  = !w_col_wrap ? r_row_ptr :
                       (w_row_wrap ? '0 : r_row_ptr + ROW_W'(1));
  assign w_wait_exit = adc_done || (r_cnt == c_timeout_last);
  assign busy        = (r_state != S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_row_ptr   <= '0;
      r_col_ptr   <= '0;
      r_cnt       <= '0;
      row_sel     <= '0;
      col_sel     <= '0;
      mux_en      <= 1'b0;
      adc_start   <= 1'b0;
      px_valid    <= 1'b0;
      px_data     <= '0;
      px_row      <= '0;
      px_col      <= '0;
      px_last     <= 1'b0;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      adc_start   <= 1'b0;
      px_valid    <= 1'b0;
      px_last     <= 1'b0;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;

      if (abort) begin
        r_state   <= S_IDLE;
        r_row_ptr <= '0;
        r_col_ptr <= '0;
        r_cnt     <= '0;
        row_sel   <= '0;
        col_sel   <= '0;
        mux_en    <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            r_row_ptr <= '0;
            r_col_ptr <= '0;
            r_cnt     <= '0;
            if (start || mode_cont) begin
              r_state     <= S_SELECT;
              row_sel     <= '0;
              col_sel     <= '0;
              mux_en      <= 1'b1;
              frame_start <= 1'b1;
              if (start) timeout_err <= 1'b0;
            end
          end
          S_SELECT: begin
            r_cnt   <= '0;
            r_state <= S_SETTLE;
          end
          S_SETTLE: begin
            if (r_cnt == c_settle_last) begin
              r_cnt     <= '0;
              r_state   <= S_CONVERT;
              adc_start <= 1'b1;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
          S_CONVERT: begin
            r_cnt   <= '0;
            r_state <= S_WAIT;
          end
          S_WAIT: begin
            if (w_wait_exit) begin
              r_cnt    <= '0;
              r_state  <= S_EMIT;
              px_valid <= 1'b1;
              px_row   <= r_row_ptr;
              px_col   <= r_col_ptr;
              px_last  <= w_last;
              px_data  <= adc_done ? adc_data : '0;
              if (!adc_done) timeout_err <= 1'b1;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
          S_EMIT: begin
            r_cnt     <= '0;
            r_row_ptr <= w_row_next;
            r_col_ptr <= w_col_next;
            row_sel   <= w_row_next;
            col_sel   <= w_col_next;
            if (!w_last) begin
              r_state <= S_SELECT;
            end else begin
              frame_done <= 1'b1;
              // Continuous mode rolls straight into the next frame's (0,0).
              if (mode_cont) begin
                r_state     <= S_SELECT;
                frame_start <= 1'b1;
              end else begin
                r_state <= S_IDLE;
                mux_en  <= 1'b0;
              end
            end
          end
          default: begin
            r_state <= S_IDLE;
            mux_en  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_matrix_scan_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// Directed bench: a 4x4 sequencer (settle 10, timeout 8) and a 5x3 sequencer
// (settle 2) driven by behavioural ADC responders, with per-scenario checks.
module tb_matrix_scan_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n = 1'b0;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp  = 0;
  int n_fail = 0;

  // ---------------- DUT A: 4x4 ----------------
  logic        a_mode_cont = 1'b0, a_start = 1'b0, a_abort = 1'b0, a_adc_done = 1'b0;
  logic [11:0] a_adc_data = '0;
  logic [1:0]  a_row_sel, a_col_sel, a_px_row, a_px_col;
  logic [11:0] a_px_data;
  logic        a_mux_en, a_adc_start, a_px_valid, a_px_last;
  logic        a_frame_start, a_frame_done, a_busy, a_timeout_err;

  matrix_scan_sequencer #(
    .ROWS(4), .COLS(4), .ROW_W(2), .COL_W(2), .DATA_W(12),
    .SETTLE_CYC(10), .TIMEOUT_CYC(8)
  ) u_dut_a (
    .clk(clk), .rst_n(rst_n), .mode_cont(a_mode_cont), .start(a_start), .abort(a_abort),
    .row_sel(a_row_sel), .col_sel(a_col_sel), .mux_en(a_mux_en), .adc_start(a_adc_start),
    .adc_done(a_adc_done), .adc_data(a_adc_data), .px_valid(a_px_valid), .px_data(a_px_data),
    .px_row(a_px_row), .px_col(a_px_col), .px_last(a_px_last), .frame_start(a_frame_start),
    .frame_done(a_frame_done), .busy(a_busy), .timeout_err(a_timeout_err)
  );

  // ---------------- DUT B: 5x3 ----------------
  logic        b_start = 1'b0, b_adc_done = 1'b0;
  logic        b_mode_cont = 1'b0, b_abort = 1'b0;
  logic [11:0] b_adc_data = '0;
  logic [2:0]  b_row_sel, b_px_row;
  logic [1:0]  b_col_sel, b_px_col;
  logic [11:0] b_px_data;
  logic        b_mux_en, b_adc_start, b_px_valid, b_px_last;
  logic        b_frame_start, b_frame_done, b_busy, b_timeout_err;

  matrix_scan_sequencer #(
    .ROWS(5), .COLS(3), .ROW_W(3), .COL_W(2), .DATA_W(12),
    .SETTLE_CYC(2), .TIMEOUT_CYC(8)
  ) u_dut_b (
    .clk(clk), .rst_n(rst_n), .mode_cont(b_mode_cont), .start(b_start), .abort(b_abort),
    .row_sel(b_row_sel), .col_sel(b_col_sel), .mux_en(b_mux_en), .adc_start(b_adc_start),
    .adc_done(b_adc_done), .adc_data(b_adc_data), .px_valid(b_px_valid), .px_data(b_px_data),
    .px_row(b_px_row), .px_col(b_px_col), .px_last(b_px_last), .frame_start(b_frame_start),
    .frame_done(b_frame_done), .busy(b_busy), .timeout_err(b_timeout_err)
  );

  wire [27:0] a_outs = {a_row_sel, a_col_sel, a_mux_en, a_adc_start, a_px_valid, a_px_data,
                        a_px_row, a_px_col, a_px_last, a_frame_start, a_frame_done, a_busy,
                        a_timeout_err};
  wire [29:0] b_outs = {b_row_sel, b_col_sel, b_mux_en, b_adc_start, b_px_valid, b_px_data,
                        b_px_row, b_px_col, b_px_last, b_frame_start, b_frame_done, b_busy,
                        b_timeout_err};

  function automatic int exp_data(input int r, input int c);
    return (r << 8) | (c << 4) | 10;
  endfunction

  // ---------------- ADC responders ----------------
  int          resp_delay = 1;
  logic        resp_en    = 1'b1;
  logic        skip_en    = 1'b0;
  logic [11:0] a_resp, b_resp;

  always begin
    @(posedge clk); #1;
    if (rst_n && resp_en && a_adc_start &&
        !(skip_en && a_row_sel == 2'd1 && a_col_sel == 2'd2)) begin
      a_resp = 12'(exp_data(int'(a_row_sel), int'(a_col_sel)));
      repeat (resp_delay) @(posedge clk);
      #1; a_adc_done = 1'b1; a_adc_data = a_resp;
      @(posedge clk); #1; a_adc_done = 1'b0;
    end
  end

  always begin
    @(posedge clk); #1;
    if (rst_n && b_adc_start) begin
      b_resp = 12'(exp_data(int'(b_row_sel), int'(b_col_sel)));
      @(posedge clk); #1; b_adc_done = 1'b1; b_adc_data = b_resp;
      @(posedge clk); #1; b_adc_done = 1'b0;
    end
  end

  // ---------------- event monitor ----------------
  typedef struct { int cyc; int row; int col; int data; logic last; logic terr; } px_t;
  px_t a_px[$], b_px[$];
  int  a_fd[$], a_fs[$], a_as[$], b_fd[$];
  px_t mon_a, mon_b;

  always @(negedge clk) begin
    if (a_px_valid) begin
      mon_a.cyc = cyc; mon_a.row = int'(a_px_row); mon_a.col = int'(a_px_col);
      mon_a.data = int'(a_px_data); mon_a.last = a_px_last; mon_a.terr = a_timeout_err;
      a_px.push_back(mon_a);
    end
    if (a_frame_done)  a_fd.push_back(cyc);
    if (a_frame_start) a_fs.push_back(cyc);
    if (a_adc_start)   a_as.push_back(cyc);
    if (b_px_valid) begin
      mon_b.cyc = cyc; mon_b.row = int'(b_px_row); mon_b.col = int'(b_px_col);
      mon_b.data = int'(b_px_data); mon_b.last = b_px_last; mon_b.terr = b_timeout_err;
      b_px.push_back(mon_b);
    end
    if (b_frame_done) b_fd.push_back(cyc);
  end

  task automatic pulse_a_start();
    @(negedge clk) a_start = 1'b1;
    @(negedge clk) a_start = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (a_outs !== 28'd0) begin n_fail++; $display("FAIL rst_a_outs: got %h want 0", a_outs); end
    n_cmp++; if (b_outs !== 30'd0) begin n_fail++; $display("FAIL rst_b_outs: got %h want 0", b_outs); end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++; if (a_busy !== 1'b0) begin n_fail++; $display("FAIL rst_idle_a: busy %b want 0", a_busy); end
  endtask

  task automatic test_single_frame();
    int base, fdb;
    resp_delay = 2; base = a_px.size(); fdb = a_fd.size();
    pulse_a_start();
    n_cmp++; if (a_busy !== 1'b1) begin n_fail++; $display("FAIL sf_busy: got %b want 1", a_busy); end
    for (int i = 0; i < 400 && a_fd.size() == fdb; i++) @(negedge clk);
    @(negedge clk);
    n_cmp++; if (a_fd.size() - fdb !== 1) begin n_fail++; $display("FAIL sf_frame_done: count %0d want 1", a_fd.size() - fdb); end
    n_cmp++; if (a_px.size() - base !== 16) begin n_fail++; $display("FAIL sf_px_count: got %0d want 16", a_px.size() - base); end
    if (a_px.size() - base >= 16 && a_fd.size() > fdb) begin
      for (int k = 0; k < 16; k++) begin
        n_cmp++;
        if (a_px[base+k].row !== k/4 || a_px[base+k].col !== k%4 ||
            a_px[base+k].data !== exp_data(k/4, k%4) || a_px[base+k].last !== (k == 15)) begin
          n_fail++;
          $display("FAIL sf_px%0d: got (%0d,%0d,%h,last=%b) want (%0d,%0d,%h,last=%b)", k,
                   a_px[base+k].row, a_px[base+k].col, a_px[base+k].data, a_px[base+k].last,
                   k/4, k%4, exp_data(k/4, k%4), k == 15);
        end
      end
      n_cmp++;
      if (a_fd[fdb] !== a_px[base+15].cyc + 1) begin
        n_fail++; $display("FAIL sf_fd_cycle: got %0d want %0d", a_fd[fdb], a_px[base+15].cyc + 1);
      end
    end
    n_cmp++; if ({a_busy, a_mux_en} !== 2'b00) begin n_fail++; $display("FAIL sf_idle: busy/mux_en %b want 00", {a_busy, a_mux_en}); end
  endtask

  task automatic test_timing();
    int base, bfs, bas, fdb;
    resp_delay = 1; base = a_px.size(); bfs = a_fs.size(); bas = a_as.size(); fdb = a_fd.size();
    pulse_a_start();
    for (int i = 0; i < 300 && a_fd.size() == fdb; i++) @(negedge clk);
    @(negedge clk);
    n_cmp++; if (a_px.size() - base !== 16) begin n_fail++; $display("FAIL tm_px_count: got %0d want 16", a_px.size() - base); end
    if (a_fs.size() > bfs && a_as.size() > bas) begin
      n_cmp++;
      if (a_as[bas] - a_fs[bfs] !== 11) begin n_fail++; $display("FAIL tm_adc_start_lat: got %0d want 11", a_as[bas] - a_fs[bfs]); end
    end
    if (a_px.size() - base >= 16) begin
      n_cmp++;
      if (a_px[base+1].cyc - a_px[base].cyc !== 14) begin n_fail++; $display("FAIL tm_spacing01: got %0d want 14", a_px[base+1].cyc - a_px[base].cyc); end
      n_cmp++;
      if (a_px[base+15].cyc - a_px[base+14].cyc !== 14) begin n_fail++; $display("FAIL tm_spacing_end: got %0d want 14", a_px[base+15].cyc - a_px[base+14].cyc); end
    end
  endtask

  task automatic test_timeout();
    int base, fdb;
    resp_delay = 1; skip_en = 1'b1; base = a_px.size(); fdb = a_fd.size();
    pulse_a_start();
    for (int i = 0; i < 400 && a_fd.size() == fdb; i++) @(negedge clk);
    @(negedge clk);
    n_cmp++; if (a_px.size() - base !== 16) begin n_fail++; $display("FAIL to_px_count: got %0d want 16", a_px.size() - base); end
    if (a_px.size() - base >= 16) begin
      n_cmp++;
      if (a_px[base+6].row !== 1 || a_px[base+6].col !== 2 || a_px[base+6].data !== 0) begin
        n_fail++; $display("FAIL to_px12: got (%0d,%0d,%h) want (1,2,0)", a_px[base+6].row, a_px[base+6].col, a_px[base+6].data);
      end
      n_cmp++;
      if (a_px[base+6].cyc - a_px[base+5].cyc !== 21) begin n_fail++; $display("FAIL to_spacing: got %0d want 21", a_px[base+6].cyc - a_px[base+5].cyc); end
      n_cmp++;
      if ({a_px[base+5].terr, a_px[base+6].terr} !== 2'b01) begin
        n_fail++; $display("FAIL to_err_edge: got %b want 01", {a_px[base+5].terr, a_px[base+6].terr});
      end
      n_cmp++;
      if (a_px[base+7].row !== 1 || a_px[base+7].col !== 3 || a_px[base+7].data !== exp_data(1, 3)) begin
        n_fail++; $display("FAIL to_px13: got (%0d,%0d,%h) want (1,3,%h)", a_px[base+7].row, a_px[base+7].col, a_px[base+7].data, exp_data(1, 3));
      end
    end
    n_cmp++; if (a_timeout_err !== 1'b1) begin n_fail++; $display("FAIL to_sticky: got %b want 1", a_timeout_err); end
    skip_en = 1'b0;
    pulse_a_start();
    n_cmp++; if ({a_timeout_err, a_busy} !== 2'b01) begin n_fail++; $display("FAIL to_clear: err/busy %b want 01", {a_timeout_err, a_busy}); end
    a_abort = 1'b1;
    @(negedge clk) a_abort = 1'b0;
    n_cmp++; if ({a_busy, a_mux_en} !== 2'b00) begin n_fail++; $display("FAIL to_abort: busy/mux_en %b want 00", {a_busy, a_mux_en}); end
  endtask

  task automatic test_continuous();
    int base, bfs, fdb;
    resp_delay = 1; base = a_px.size(); bfs = a_fs.size(); fdb = a_fd.size();
    @(negedge clk) a_mode_cont = 1'b1;
    for (int i = 0; i < 600 && a_px.size() - base < 20; i++) @(negedge clk);
    a_mode_cont = 1'b0;
    for (int i = 0; i < 400 && a_fd.size() - fdb < 2; i++) @(negedge clk);
    repeat (40) @(negedge clk);
    n_cmp++; if (a_px.size() - base !== 32) begin n_fail++; $display("FAIL ct_px_count: got %0d want 32", a_px.size() - base); end
    n_cmp++; if (a_fd.size() - fdb !== 2) begin n_fail++; $display("FAIL ct_fd_count: got %0d want 2", a_fd.size() - fdb); end
    n_cmp++; if (a_fs.size() - bfs !== 2) begin n_fail++; $display("FAIL ct_fs_count: got %0d want 2", a_fs.size() - bfs); end
    if (a_px.size() - base >= 32 && a_fs.size() - bfs >= 2 && a_fd.size() - fdb >= 2) begin
      n_cmp++;
      if (a_fs[bfs+1] !== a_px[base+15].cyc + 1) begin n_fail++; $display("FAIL ct_no_gap: select at %0d want %0d", a_fs[bfs+1], a_px[base+15].cyc + 1); end
      n_cmp++;
      if (a_fd[fdb] !== a_px[base+15].cyc + 1) begin n_fail++; $display("FAIL ct_fd1: got %0d want %0d", a_fd[fdb], a_px[base+15].cyc + 1); end
      n_cmp++;
      if (a_px[base+16].row !== 0 || a_px[base+16].col !== 0 || a_px[base+31].last !== 1'b1) begin
        n_fail++; $display("FAIL ct_frame2: first (%0d,%0d) last=%b want (0,0) last=1", a_px[base+16].row, a_px[base+16].col, a_px[base+31].last);
      end
    end
    n_cmp++; if (a_busy !== 1'b0) begin n_fail++; $display("FAIL ct_idle: busy %b want 0", a_busy); end
  endtask

  task automatic test_abort();
    int base, base2, fdb;
    resp_delay = 1; base = a_px.size(); fdb = a_fd.size();
    pulse_a_start();
    for (int i = 0; i < 300 && !(a_px_valid === 1'b1 && a_px_row == 2'd2 && a_px_col == 2'd0); i++) @(negedge clk);
    @(negedge clk);
    n_cmp++; if ({a_row_sel, a_col_sel, a_mux_en} !== {2'd2, 2'd1, 1'b1}) begin
      n_fail++; $display("FAIL ab_select21: got row %0d col %0d en %b want 2 1 1", a_row_sel, a_col_sel, a_mux_en);
    end
    @(negedge clk) a_abort = 1'b1;
    @(negedge clk) a_abort = 1'b0;
    n_cmp++; if ({a_busy, a_mux_en, a_adc_start, a_px_valid} !== 4'b0000) begin
      n_fail++; $display("FAIL ab_settle: busy/en/start/valid %b want 0000", {a_busy, a_mux_en, a_adc_start, a_px_valid});
    end
    repeat (30) @(negedge clk);
    n_cmp++; if (a_px.size() - base !== 9 || a_fd.size() !== fdb) begin
      n_fail++; $display("FAIL ab_no_output: px %0d fd %0d want 9 0", a_px.size() - base, a_fd.size() - fdb);
    end
    base2 = a_px.size();
    pulse_a_start();
    for (int i = 0; i < 40 && a_px_valid !== 1'b1; i++) @(negedge clk);
    n_cmp++; if ({a_px_valid, a_px_row, a_px_col} !== {1'b1, 2'd0, 2'd0}) begin
      n_fail++; $display("FAIL ab_rescan: valid %b row %0d col %0d want 1 0 0", a_px_valid, a_px_row, a_px_col);
    end
    for (int i = 0; i < 40 && a_adc_start !== 1'b1; i++) @(negedge clk);
    @(posedge clk); #1 a_abort = 1'b1;
    @(posedge clk); #1 a_abort = 1'b0;
    @(negedge clk);
    n_cmp++; if ({a_busy, a_px_valid} !== 2'b00) begin n_fail++; $display("FAIL ab_done_race: busy/valid %b want 00", {a_busy, a_px_valid}); end
    repeat (20) @(negedge clk);
    n_cmp++; if (a_px.size() - base2 !== 1 || a_fd.size() !== fdb) begin
      n_fail++; $display("FAIL ab_discard: px %0d fd %0d want 1 0", a_px.size() - base2, a_fd.size() - fdb);
    end
  endtask

  task automatic test_async_reset();
    resp_en = 1'b0;
    pulse_a_start();
    for (int i = 0; i < 40 && a_adc_start !== 1'b1; i++) @(negedge clk);
    @(posedge clk); #2;
    n_cmp++; if ({a_busy, a_mux_en} !== 2'b11) begin n_fail++; $display("FAIL ar_pre: busy/mux_en %b want 11", {a_busy, a_mux_en}); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (a_outs !== 28'd0) begin n_fail++; $display("FAIL ar_async: got %h want 0", a_outs); end
    @(negedge clk) rst_n = 1'b1;
    resp_en = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++; if (a_busy !== 1'b0) begin n_fail++; $display("FAIL ar_idle: busy %b want 0", a_busy); end
  endtask

  task automatic test_wrap_5x3();
    int base, fdb;
    base = b_px.size(); fdb = b_fd.size();
    @(negedge clk) b_start = 1'b1;
    @(negedge clk) b_start = 1'b0;
    for (int i = 0; i < 200 && b_fd.size() == fdb; i++) @(negedge clk);
    @(negedge clk);
    n_cmp++; if (b_px.size() - base !== 15 || b_fd.size() - fdb !== 1) begin
      n_fail++; $display("FAIL wr_count: px %0d fd %0d want 15 1", b_px.size() - base, b_fd.size() - fdb);
    end
    if (b_px.size() - base >= 15 && b_fd.size() > fdb) begin
      for (int k = 0; k < 15; k++) begin
        n_cmp++;
        if (b_px[base+k].row !== k/3 || b_px[base+k].col !== k%3 ||
            b_px[base+k].data !== exp_data(k/3, k%3) || b_px[base+k].last !== (k == 14)) begin
          n_fail++;
          $display("FAIL wr_px%0d: got (%0d,%0d,%h,last=%b) want (%0d,%0d,%h,last=%b)", k,
                   b_px[base+k].row, b_px[base+k].col, b_px[base+k].data, b_px[base+k].last,
                   k/3, k%3, exp_data(k/3, k%3), k == 14);
        end
      end
      n_cmp++;
      if (b_fd[fdb] !== b_px[base+14].cyc + 1) begin n_fail++; $display("FAIL wr_fd_cycle: got %0d want %0d", b_fd[fdb], b_px[base+14].cyc + 1); end
    end
    n_cmp++; if (b_busy !== 1'b0) begin n_fail++; $display("FAIL wr_idle: busy %b want 0", b_busy); end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_timing();
    test_timeout();
    test_continuous();
    test_abort();
    test_async_reset();
    test_wrap_5x3();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
